stopwatch_fsm: RTL
==================

# stopwatch_fsm

Run-control sequencer for the stopwatch/countdown time datapath. It sits between the debounced button bank and the time counter. It turns button levels into counter commands: step enable, count direction, clear, and minute/hour increments. It also raises a blinking alarm when a countdown reaches zero. One instance per timer, clocked with the debounced buttons in the 200 Hz domain; `tick_100hz` is a one-cycle strobe in that domain.

## Interface
- `HOLD_TICKS`, 50 — ticks a set button must stay held before auto-repeat starts; must be 1..127.
- `REPEAT_TICKS`, 20 — ticks between auto-repeat increments; must be 1..127.
- `BLINK_TICKS`, 25 — alarm half-period, in ticks; must be 1..127.
- `clk` input 1 — the single clock; all logic is on the rising edge.
- `rst` input 1 — reset; asynchronous, active-low.
- `tick_100hz` input 1 — one-cycle strobe, 100 Hz.
- `btn_start`, `btn_stop`, `btn_set_min`, `btn_set_hour`, `btn_clr` input 1 each — debounced button levels, active-high.
- `countdown_mode` input 1 — debounced switch level; 1 = count down.
- `cnt_zero` input 1 — datapath reads 00:00:00.00.
- `cnt_step` output 1 — one-cycle pulse; datapath advances by 1 centisecond.
- `cnt_dir` output 1 — 0 = up, 1 = down.
- `cnt_clr` output 1 — one-cycle pulse; datapath clears to zero.
- `inc_min`, `inc_hour` output 1 — one-cycle pulses; datapath adds 1 to the field (wrap is done by the datapath).
- `state` output 2 — 0 IDLE, 1 RUN, 2 PAUSE, 3 DONE.
- `alarm` output 1 — blink level, high only in DONE.

## Operation
- Each button gets a one-stage history register; "press" means level = 1 and history = 0 in the same cycle. A held button produces exactly one press.
- Priority among same-cycle presses: clr > stop > start > set_hour > set_min. Only the highest-priority press acts.
- clr, in any state: go to IDLE, pulse `cnt_clr`, clear the alarm and repeat counters.
- IDLE:
  - `cnt_dir` follows `countdown_mode` every cycle.
  - start → RUN, except when `countdown_mode` = 1 and `cnt_zero` = 1: then start is ignored.
  - set_min → `inc_min`; set_hour → `inc_hour`.
- RUN:
  - `cnt_dir` is frozen; changes to `countdown_mode` are ignored.
  - On each tick: if `cnt_dir` = 1 and `cnt_zero` = 1, go to DONE with no step; otherwise pulse `cnt_step`.
  - stop → PAUSE. set_min and set_hour are ignored.
- PAUSE:
  - start → RUN, except with the same countdown-at-zero block as IDLE.
  - set_min and set_hour act as in IDLE. `cnt_dir` stays frozen.
- DONE:
  - `alarm` toggles every `BLINK_TICKS` ticks; the first level is 1 on entry.
  - Any press of start, stop, set_min or set_hour, or `countdown_mode` falling to 0, → IDLE with `alarm` = 0. The press itself has no other effect.
- Up-count overflow is wrapped by the datapath; this block takes no action.

## Timing
- Reset values: `state` = IDLE, `cnt_dir` = 0, `alarm` = 0. `cnt_step`, `cnt_clr`, `inc_min` and `inc_hour` are all 0. All history and counter registers are 0.
- All outputs are registered. A press or tick sampled at edge k produces its output pulse and new `state` from edge k+1, for exactly one cycle.
- Latency from press or tick to action is 1 cycle. A press coinciding with a tick is handled in the same cycle: stop on a RUN tick → PAUSE with no step issued.
- `cnt_step` never coincides with `cnt_clr`; clr wins.
- Reset asserted mid-run: outputs take their reset values immediately (asynchronously). The datapath value is not touched.

## Configuration
- `STOPWATCH_AUTOREPEAT_EN` defined:
  - A set button held continuously counts ticks from its press.
  - After `HOLD_TICKS` ticks it issues one increment, then one every `REPEAT_TICKS` ticks while still held, in IDLE and PAUSE only.
  - Release, a state change, or a higher-priority press resets the hold counter.
- Not defined: exactly one increment per press; hold counters are not built.

## Test plan
- Reset, then start, then 300 ticks → 300 `cnt_step` pulses, `state` = 1. Stop on tick 301 → `state` = 2, no 301st step.
- `countdown_mode` = 1, `cnt_zero` = 1, start → `state` stays 0, no pulses. Drop `cnt_zero`, start → RUN with `cnt_dir` = 1.
- Countdown RUN, raise `cnt_zero` before a tick → `state` = 3 next cycle. `alarm` = 1 for 25 ticks then 0 for 25. Stop press → IDLE, `alarm` = 0.
- Start and clr pressed in the same cycle while in IDLE → single `cnt_clr` pulse, `state` = 0, no RUN.
- Hold set_min in PAUSE for 110 ticks → with `STOPWATCH_AUTOREPEAT_EN`, 1 + 1 + 3 = 5 `inc_min` pulses (press, tick 50, ticks 70/90/110); without it, 1 pulse.
- In RUN, assert reset with `cnt_step` due → `state` = 0, `cnt_step` = 0 immediately, and it stays 0 after release.

Source files
------------

// File: rtl/stopwatch_fsm.sv
// stopwatch_fsm: run-control sequencer for the stopwatch/countdown datapath.
// Turns debounced button levels into one-cycle counter commands.
// Inputs and outputs belong to the 200 Hz domain, and every output is registered.
// Optional feature macro: STOPWATCH_AUTOREPEAT_EN. When it is defined, a held
// set_min or set_hour button auto-repeats its increment.
module stopwatch_fsm #(
  parameter int HOLD_TICKS   = 50,
  parameter int REPEAT_TICKS = 20,
  parameter int BLINK_TICKS  = 25
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_100hz,
  input  logic       btn_start,
  input  logic       btn_stop,
  input  logic       btn_set_min,
  input  logic       btn_set_hour,
  input  logic       btn_clr,
  input  logic       countdown_mode,
  input  logic       cnt_zero,
  output logic       cnt_step,
  output logic       cnt_dir,
  output logic       cnt_clr,
  output logic       inc_min,
  output logic       inc_hour,
  output logic [1:0] state,
  output logic       alarm
);

  // Reject tick parameters that do not fit the 7-bit tick counters.
  if (HOLD_TICKS < 1 || HOLD_TICKS > 127) begin : g_bad_hold
    $error("HOLD_TICKS must be 1..127");
  end
  if (REPEAT_TICKS < 1 || REPEAT_TICKS > 127) begin : g_bad_repeat
    $error("REPEAT_TICKS must be 1..127");
  end
  if (BLINK_TICKS < 1 || BLINK_TICKS > 127) begin : g_bad_blink
    $error("BLINK_TICKS must be 1..127");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_e;

  // The highest-priority press seen in this cycle.
  typedef enum logic [2:0] {
    P_NONE, P_CLR, P_STOP, P_START, P_HOUR, P_MIN
  } press_e;

  localparam logic [6:0] BLINK_LAST = 7'(BLINK_TICKS - 1);

  state_e     state_q, state_d;
  logic       dir_q, dir_d;
  logic       alarm_q, alarm_d;
  logic       step_q, step_d;
  logic       clr_q, clr_d;
  logic       inc_min_q, inc_min_d;
  logic       inc_hour_q, inc_hour_d;
  logic [6:0] blink_q, blink_d;
  // Bit order of the history vector and the press vector: clr, stop, start, set_hour, set_min.
  logic [4:0] hist_q, hist_d;
  logic [4:0] press;
  press_e     top;

`ifdef STOPWATCH_AUTOREPEAT_EN
  localparam logic [6:0] HOLD_LAST   = 7'(HOLD_TICKS - 1);
  localparam logic [6:0] REPEAT_LAST = 7'(REPEAT_TICKS - 1);

  typedef enum logic [1:0] {H_OFF, H_HOLD, H_REPEAT} hold_phase_e;
  typedef struct packed {
    hold_phase_e phase;
    logic [6:0]  cnt;
  } hold_t;

  hold_t hold_min_q, hold_min_d, hold_hour_q, hold_hour_d;
  logic  in_setup, keep_min, keep_hour, fire_min, fire_hour;

  // Advance one set button's hold timer. A press arms the timer. Losing the
  // keep condition disarms it. An armed timer counts ticks and fires first
  // after HOLD_TICKS ticks and then every REPEAT_TICKS ticks.
  function automatic void hold_step(input hold_t cur, input logic arm, input logic keep,
                                    input logic tick, output hold_t nxt, output logic fire);
    nxt  = cur;
    fire = 1'b0;
    if (arm) begin
      nxt.phase = H_HOLD;
      nxt.cnt   = '0;
    end else if (!keep) begin
      nxt.phase = H_OFF;
      nxt.cnt   = '0;
    end else if (tick && cur.phase != H_OFF) begin
      if ((cur.phase == H_HOLD && cur.cnt == HOLD_LAST) ||
          (cur.phase == H_REPEAT && cur.cnt == REPEAT_LAST)) begin
        fire      = 1'b1;
        nxt.phase = H_REPEAT;
        nxt.cnt   = '0;
      end else begin
        nxt.cnt = cur.cnt + 7'd1;
      end
    end
  endfunction
`endif

  // Detect presses, pick the winner, and compute the next state and pulses.
  always_comb begin
    // NOTE: every _d signal takes its hold value before any branch. No path can leave it unassigned, so no latch is inferred.
    hist_d     = {btn_clr, btn_stop, btn_start, btn_set_hour, btn_set_min};
    press      = hist_d & ~hist_q;
    state_d    = state_q;
    dir_d      = dir_q;
    alarm_d    = alarm_q;
    blink_d    = blink_q;
    step_d     = 1'b0;
    clr_d      = 1'b0;
    inc_min_d  = 1'b0;
    inc_hour_d = 1'b0;

    if      (press[4]) top = P_CLR;
    else if (press[3]) top = P_STOP;
    else if (press[2]) top = P_START;
    else if (press[1]) top = P_HOUR;
    else if (press[0]) top = P_MIN;
    else               top = P_NONE;

    // Direction tracks the switch only while idle. Otherwise it stays frozen.
    if (state_q == IDLE) dir_d = countdown_mode;

    if (top == P_CLR) begin
      state_d = IDLE;
      clr_d   = 1'b1;
      alarm_d = 1'b0;
      blink_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          case (top)
            P_START: if (!(countdown_mode && cnt_zero)) state_d = RUN;
            P_HOUR:  inc_hour_d = 1'b1;
            P_MIN:   inc_min_d  = 1'b1;
            default: ;
          endcase
        end
        RUN: begin
          if (top == P_STOP) begin
            state_d = PAUSE;
          end else if (tick_100hz) begin
            if (dir_q && cnt_zero) begin
              state_d = DONE;
              alarm_d = 1'b1;
              blink_d = '0;
            end else begin
              step_d = 1'b1;
            end
          end
        end
        PAUSE: begin
          // Direction is frozen here, so the zero block uses the frozen direction.
          case (top)
            P_START: if (!(dir_q && cnt_zero)) state_d = RUN;
            P_HOUR:  inc_hour_d = 1'b1;
            P_MIN:   inc_min_d  = 1'b1;
            default: ;
          endcase
        end
        DONE: begin
          if (top != P_NONE || !countdown_mode) begin
            state_d = IDLE;
            alarm_d = 1'b0;
            blink_d = '0;
          end else if (tick_100hz) begin
            if (blink_q == BLINK_LAST) begin
              alarm_d = ~alarm_q;
              blink_d = '0;
            end else begin
              blink_d = blink_q + 7'd1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end

`ifdef STOPWATCH_AUTOREPEAT_EN
    in_setup  = (state_q == IDLE) || (state_q == PAUSE);
    keep_min  = btn_set_min && in_setup && (state_d == state_q) &&
                !(top inside {P_CLR, P_STOP, P_START, P_HOUR});
    keep_hour = btn_set_hour && in_setup && (state_d == state_q) &&
                !(top inside {P_CLR, P_STOP, P_START});
    hold_step(hold_min_q, (top == P_MIN) && in_setup, keep_min, tick_100hz,
              hold_min_d, fire_min);
    hold_step(hold_hour_q, (top == P_HOUR) && in_setup, keep_hour, tick_100hz,
              hold_hour_d, fire_hour);
    inc_min_d  = inc_min_d | fire_min;
    inc_hour_d = inc_hour_d | fire_hour;
`endif
  end

  // Register the state, the output pulses, the history and the counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      dir_q       <= 1'b0;
      alarm_q     <= 1'b0;
      step_q      <= 1'b0;
      clr_q       <= 1'b0;
      inc_min_q   <= 1'b0;
      inc_hour_q  <= 1'b0;
      blink_q     <= '0;
      hist_q      <= '0;
`ifdef STOPWATCH_AUTOREPEAT_EN
      hold_min_q  <= '{phase: H_OFF, cnt: '0};
      hold_hour_q <= '{phase: H_OFF, cnt: '0};
`endif
    end else begin
      // NOTE: non-blocking assignments make every register update from the same pre-edge values.
      state_q     <= state_d;
      dir_q       <= dir_d;
      alarm_q     <= alarm_d;
      step_q      <= step_d;
      clr_q       <= clr_d;
      inc_min_q   <= inc_min_d;
      inc_hour_q  <= inc_hour_d;
      blink_q     <= blink_d;
      hist_q      <= hist_d;
`ifdef STOPWATCH_AUTOREPEAT_EN
      hold_min_q  <= hold_min_d;
      hold_hour_q <= hold_hour_d;
`endif
    end
  end

  assign state    = state_q;
  assign cnt_dir  = dir_q;
  assign alarm    = alarm_q;
  assign cnt_step = step_q;
  assign cnt_clr  = clr_q;
  assign inc_min  = inc_min_q;
  assign inc_hour = inc_hour_q;

endmodule
